// File: rtl/rv32_pkg.sv
// rv32_pkg: shared types and sizes for the RV32 integer register file.
//
// Contents:
//   XLEN         register data width (32)
//   NREG         number of architectural registers, x0 included (32)
//   AW           register index width, log2(NREG) (5)
//   reg_idx_t    register index type
//   xword_t      register data word type
//   busy_state_t per-register load scoreboard state (IDLE / PEND)
package rv32_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef logic [AW-1:0]   reg_idx_t;
  typedef logic [XLEN-1:0] xword_t;

  // A register is PEND while a load that targets it has been issued
  // but has not yet written back.
  typedef enum logic {
    BUSY_IDLE = 1'b0,
    BUSY_PEND = 1'b1
  } busy_state_t;

endpackage

// File: rtl/reg_file_busy_scoreboard.sv
// busy_scoreboard: per-register outstanding-load tracker and load-use
// stall generation for the ID stage.
//
// Ports:
//   clk        in   core clock, state updates on rising edge
//   rst_n      in   asynchronous active-low reset, clears every busy bit
//   set_busy   in   ID issues a load to busy_addr
//   busy_addr  in   load destination index
//   clr_en     in   WB write enable (op_write)
//   clr_addr   in   WB destination index (already truncated to AW bits)
//   rs1_addr   in   ID source index 1
//   rs2_addr   in   ID source index 2
//   stall_id   out  a non-zero source of the ID instruction is busy
//
// Build option: REG_FILE_BYPASS_EN makes a same-cycle WB write to a busy
// source clear that source's stall term combinationally.
import rv32_pkg::*;

module busy_scoreboard (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     set_busy,
  input  reg_idx_t busy_addr,
  input  logic     clr_en,
  input  reg_idx_t clr_addr,
  input  reg_idx_t rs1_addr,
  input  reg_idx_t rs2_addr,
  output logic     stall_id
);

  logic [NREG-1:0] busy_vec;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
    if (gi == 0) begin : g_x0
      // x0 can never hold a pending load.
      assign busy_vec[gi] = 1'b0;
    end else begin : g_reg
      busy_state_t state_q;
      busy_state_t state_d;
      logic        set_hit;
      logic        clr_hit;

      assign set_hit = set_busy && (busy_addr == reg_idx_t'(gi));
      assign clr_hit = clr_en   && (clr_addr  == reg_idx_t'(gi));

      always_comb begin
        state_d = state_q;
        case (state_q)
          BUSY_IDLE: if (set_hit) state_d = BUSY_PEND;
          // A coincident set means a newer load owns the register, so
          // the write-back of the older one must not release it.
          BUSY_PEND: if (clr_hit && !set_hit) state_d = BUSY_IDLE;
          default:   state_d = BUSY_IDLE;
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= BUSY_IDLE;
        end else begin
          state_q <= state_d;
        end
      end

      assign busy_vec[gi] = (state_q == BUSY_PEND);
    end
  end

  logic rs1_busy;
  logic rs2_busy;

  always_comb begin
    rs1_busy = busy_vec[rs1_addr] && (rs1_addr != '0);
    rs2_busy = busy_vec[rs2_addr] && (rs2_addr != '0);
`ifdef REG_FILE_BYPASS_EN
    // The forwarded write-back satisfies the dependency this cycle.
    if (clr_en && (clr_addr == rs1_addr)) rs1_busy = 1'b0;
    if (clr_en && (clr_addr == rs2_addr)) rs2_busy = 1'b0;
`endif
    stall_id = rs1_busy || rs2_busy;
  end

endmodule

// File: rtl/reg_file.sv
// reg_file: RV32 integer register file, consumer end of the write-back
// interface. Two combinational read ports for ID, one write port from WB,
// and a busy scoreboard for outstanding loads (load-use stall).
//
// Ports:
//   clk         in   core clock, state updates on rising edge
//   rst_n       in   asynchronous active-low reset (registers and busy bits)
//   op_write    in   WB write enable
//   write_data  in   WB result
//   write_addr  in   WB destination; only bits [AW-1:0] are used
//   rs1_addr    in   read port 1 index
//   rs2_addr    in   read port 2 index
//   rs1_data    out  read port 1 data (x0 reads 0)
//   rs2_data    out  read port 2 data (x0 reads 0)
//   set_busy    in   ID issues a load; mark busy_addr pending
//   busy_addr   in   load destination index
//   stall_id    out  rs1 or rs2 of the ID instruction is busy
//
// Build option: REG_FILE_BYPASS_EN forwards a same-cycle WB write to the
// read ports and clears the matching stall term in the same cycle.
// Without it, reads return the stored value.
import rv32_pkg::*;

module reg_file (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_write,
  input  xword_t      write_data,
  input  logic [31:0] write_addr,
  input  reg_idx_t    rs1_addr,
  input  reg_idx_t    rs2_addr,
  output xword_t      rs1_data,
  output xword_t      rs2_data,
  input  logic        set_busy,
  input  reg_idx_t    busy_addr,
  output logic        stall_id
);

  reg_idx_t wr_idx;
  logic     wr_en;
  logic     unused_write_addr_hi;

  assign wr_idx = write_addr[AW-1:0];
  // Writes to x0 are dropped here so x0 never changes.
  assign wr_en  = op_write && (wr_idx != '0);
  assign unused_write_addr_hi = ^write_addr[31:AW];

  xword_t regs_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wr_idx] <= write_data;
    end
  end

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != '0) rs1_data = regs_q[rs1_addr];
    if (rs2_addr != '0) rs2_data = regs_q[rs2_addr];
`ifdef REG_FILE_BYPASS_EN
    if (wr_en && (wr_idx == rs1_addr)) rs1_data = write_data;
    if (wr_en && (wr_idx == rs2_addr)) rs2_data = write_data;
`endif
  end

  busy_scoreboard u_busy_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_busy  (set_busy),
    .busy_addr (busy_addr),
    .clr_en    (op_write),
    .clr_addr  (wr_idx),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .stall_id  (stall_id)
  );

endmodule

// File: doc/reg_file.md
# reg_file

Integer register file for the 32-bit RISC-V core: the consumer end of the write-back interface. Captures `op_write`/`write_data`/`write_addr` from the WB stage on each clock edge and serves two combinational read ports to the ID stage. Holds a per-register busy scoreboard for outstanding loads, so ID can detect load-use hazards and stall.

## Interface
- `XLEN`, 32, register data width
- `NREG`, 32, number of architectural registers; x0 included
- `AW`, 5, register index width, log2(`NREG`)
- `clk`  input  1  core clock; all state updates on rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `op_write`  input  1  WB write enable, equal to `ctrl_wb[0]` of the WB stage
- `write_data`  input  `XLEN`  WB result: ALU, memory or PC+4
- `write_addr`  input  32  WB destination index; only bits [`AW`-1:0] are used, upper bits ignored
- `rs1_addr`  input  `AW`  ID read port 1 index
- `rs2_addr`  input  `AW`  ID read port 2 index
- `rs1_data`  output  `XLEN`  read port 1 data
- `rs2_data`  output  `XLEN`  read port 2 data
- `set_busy`  input  1  ID issues a load; mark `busy_addr` pending
- `busy_addr`  input  `AW`  load destination index
- `stall_id`  output  1  rs1 or rs2 of the current ID instruction is busy

## Operation
- Storage: `NREG` x `XLEN` flops; x0 is hard-wired to 0. Writes to x0 are dropped and x0 is never marked busy.
- Write: on rising `clk`, if `op_write`=1 and `write_addr[AW-1:0]`≠0, load `write_data` into that register.
- Read: `rsN_data` = reg[`rsN_addr`], combinational. Index 0 always reads 0.
- Scoreboard: one busy bit per register.
  - Set on rising `clk` when `set_busy`=1 and `busy_addr`≠0.
  - Cleared on rising `clk` when a WB write (`op_write`=1) targets that index.
  - Set and clear on the same index in the same cycle: set wins, because the newer load owns the register.
  - Set and clear on different indices in the same cycle: both take effect.
- `stall_id` = (busy[`rs1_addr`] & `rs1_addr`≠0) | (busy[`rs2_addr`] & `rs2_addr`≠0), combinational.
- Each busy bit is a 2-state FSM per register: IDLE→PEND on set, PEND→IDLE on clearing write, PEND→PEND when set and clear coincide.
- A WB write to a non-busy register still writes data. Busy bits only gate `stall_id`.

## Timing
- Reset (`rst_n`=0, asynchronous): all registers are 0 and all busy bits are 0, so `rs1_data`=`rs2_data`=0 and `stall_id`=0. Reset takes effect immediately, including mid-write. Release is synchronous to `clk`.
- Write latency: data is visible on a read port the cycle after the write edge (without bypass).
- Read latency: 0 cycles, combinational from the address.
- `stall_id` reflects busy state after the most recent edge. A WB clear makes `stall_id` drop in the following cycle (without bypass).

## Configuration
- `REG_FILE_BYPASS_EN` defined: write-through forwarding.
  - If `op_write`=1, `write_addr[AW-1:0]`=`rsN_addr`, and the index is ≠0, then `rsN_data`=`write_data` in the same cycle.
  - A WB write that matches a busy rs clears that term of `stall_id` combinationally in the same cycle.
- Undefined: reads return the stored value, so a same-cycle write returns the old value, and stall clears one cycle after the WB write.

## Structure
- Shared package `rv32_pkg`: `XLEN`, `NREG`, `AW`, and the `reg_idx_t` and `xword_t` typedefs.
- One natural sub-module, `busy_scoreboard`: busy bit vector, set/clear logic and `stall_id` generation. The data array and read muxes stay in `reg_file`.

## Test plan
- Reset check: assert `rst_n`=0 mid-run after writing x5=0x1234. Expect `rs1_data`(x5)=0 and `stall_id`=0 immediately.
- Basic write/read: `op_write`=1, `write_addr`=3, `write_data`=0xDEADBEEF. The next cycle `rs1_addr`=3 reads 0xDEADBEEF. `write_addr`=0x23 (upper bits set) also writes x3.
- x0 protection: write 0xFFFFFFFF to x0 and `set_busy` x0. Expect reads of x0 = 0 and `stall_id`=0 for `rs1_addr`=0.
- Same-cycle read/write, with x7 holding 5, writing 9 and reading x7:
  - without `REG_FILE_BYPASS_EN`: `rs2_data`=5, then 9 the next cycle;
  - with the macro: 9 immediately.
- Load-use stall:
  - `set_busy`, `busy_addr`=10, then `rs1_addr`=10: `stall_id`=1.
  - A WB write to x10 clears it: `stall_id`=0 the next cycle (same cycle with bypass).
- Simultaneous set/clear: x12 busy, WB write x12 and `set_busy` x12 in the same cycle. Expect x12 still busy (`stall_id`=1) and x12 holds the WB data.
